// File: rtl/instr_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder_pkg
// Purpose  : Shared state encoding, word geometry and sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_responder_pkg;

  localparam int RV32_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IMEM_ST_IDLE = 2'd0,
    IMEM_ST_WAIT = 2'd1,
    IMEM_ST_RESP = 2'd2
  } imem_state_e;

  // Width of a word index into the byte store; never narrower than one bit.
  function automatic int widx_width(input int depth_bytes);
    int aw;
    aw = $clog2(depth_bytes);
    return (aw > 2) ? aw - 2 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder_byte_ram
// Purpose  : Byte-wide write, combinational 32-bit little-endian word read.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder_byte_ram
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES),
  parameter int WIDX_W      = widx_width(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [7:0]        wdata,
  input  logic [WIDX_W-1:0] rd_widx,
  output logic [31:0]       rd_word
);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] base;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign base = AW'({rd_widx, 2'b00});

  // Lowest address lands in the least significant byte of the word.
  for (genvar i = 0; i < RV32_WORD_BYTES; i++) begin : g_rd
    assign rd_word[8*i +: 8] = mem[base | AW'(i)];
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Purpose  : Fixed-latency instruction fetch responder with byte load port.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           req_ready,
  output logic                           resp_valid,
  output logic [31:0]                    resp_data,
  output logic                           resp_err,
  input  logic                           resp_ready,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_BYTES)-1:0] load_addr,
  input  logic [7:0]                     load_data,
  output logic                           busy
);

  localparam int LOAD_AW = $clog2(DEPTH_BYTES);
  localparam int WIDX_W  = widx_width(DEPTH_BYTES);
  localparam int CNT_W   = $clog2(LATENCY + 1);

  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - RV32_WORD_BYTES);
  localparam logic [CNT_W-1:0]  CNT_INIT       = CNT_W'(LATENCY - 1);

  imem_state_e       state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              accept;
  logic              misaligned, out_of_range, fetch_err;
  logic [WIDX_W-1:0] word_idx;
  logic [31:0]       ram_word;

  // Any address bit above the store counts as out of range: no aliasing.
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr > LAST_WORD_ADDR);
  assign fetch_err    = misaligned | out_of_range;
  assign word_idx     = WIDX_W'(req_addr >> 2);

  instr_mem_responder_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (LOAD_AW),
    .WIDX_W      (WIDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (load_en),
    .waddr   (load_addr),
    .wdata   (load_data),
    .rd_widx (word_idx),
    .rd_word (ram_word)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    req_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IMEM_ST_IDLE: begin
        // A pending byte load blocks acceptance so the two never share an edge.
        req_ready = !load_en;
        accept    = req_valid && !load_en;
        if (accept) begin
          count_next = CNT_INIT;
          state_next = (LATENCY == 1) ? IMEM_ST_RESP : IMEM_ST_WAIT;
        end
      end
      IMEM_ST_WAIT: begin
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_next = IMEM_ST_RESP;
        end
      end
      IMEM_ST_RESP: begin
        if (resp_ready) begin
          state_next = IMEM_ST_IDLE;
        end
      end
      default: begin
        state_next = IMEM_ST_IDLE;
      end
    endcase
    resp_valid = (state == IMEM_ST_RESP);
    busy       = (state != IMEM_ST_IDLE);
  end

  // Response is captured at accept, so later loads cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IMEM_ST_IDLE;
      count     <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        resp_data <= fetch_err ? 32'h0 : ram_word;
        resp_err  <= fetch_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// Scoreboard bench: stimulus pushes model-predicted responses, a negedge
// monitor pops and compares whenever the responder hands a word over.
module tb_instr_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = 32;
  localparam int LAW   = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic           req_ready;
  logic           resp_valid;
  logic [31:0]    resp_data;
  logic           resp_err;
  logic           resp_ready = 1'b1;
  logic           load_en = 1'b0;
  logic [LAW-1:0] load_addr = '0;
  logic [7:0]     load_data = '0;
  logic           busy;

  instr_mem_responder #(
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_model [DEPTH];

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] last_data = '0;
  logic        last_err  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: little-endian word of the byte model, zero on any bad address.
  function automatic exp_t model_fetch(input logic [31:0] a, input int acc);
    exp_t e;
    int   idx;
    e.acc = acc;
    e.err = (a % 4 != 0) || (a > 32'(DEPTH - 4));
    if (e.err) begin
      e.data = 32'h0;
    end else begin
      idx    = int'(a);
      e.data = {mem_model[idx+3], mem_model[idx+2], mem_model[idx+1], mem_model[idx]};
    end
    return e;
  endfunction

  // Monitor
  logic        prev_valid    = 1'b0;
  logic        prev_consumed = 1'b0;
  logic [31:0] prev_data     = '0;
  logic        prev_err      = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid    = 1'b0;
      prev_consumed = 1'b0;
    end else begin
      if (prev_consumed) chk("idle_after_consume", {63'b0, busy}, 64'd0);
      prev_consumed = 1'b0;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          if (!prev_valid) begin
            chk("latency", 64'(cyc - sb[0].acc + 1), 64'(LAT));
          end else begin
            chk("hold_data", {32'b0, resp_data}, {32'b0, prev_data});
            chk("hold_err", {63'b0, resp_err}, {63'b0, prev_err});
          end
          if (resp_ready) begin
            chk("resp_data", {32'b0, resp_data}, {32'b0, sb[0].data});
            chk("resp_err", {63'b0, resp_err}, {63'b0, sb[0].err});
            last_data = resp_data;
            last_err  = resp_err;
            void'(sb.pop_front());
            prev_consumed = 1'b1;
          end
        end
      end
      prev_valid = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_err   = resp_err;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic drive_load(input logic [LAW-1:0] a, input logic [7:0] d);
    load_en      = 1'b1;
    load_addr    = a;
    load_data    = d;
    mem_model[a] = d;
  endtask

  task automatic load_byte(input logic [LAW-1:0] a, input logic [7:0] d, input bit check_ready);
    tick();
    drive_load(a, d);
    if (check_ready) begin
      #1;
      chk("req_ready_during_load", {63'b0, req_ready}, 64'd0);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    bit done = 1'b0;
    tick();
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(model_fetch(a, cyc + 1));
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit randomize_env);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        load_en = 1'b0;
        if (randomize_env) begin
          resp_ready = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0)
            drive_load(LAW'($urandom_range(0, DEPTH - 1)), 8'($urandom));
        end
      end
    end
    if (!done) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    bit          seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_resp_data", {32'b0, resp_data}, 64'd0);
    chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load_byte(LAW'(i), 8'($urandom), 1'b0);
    load_byte(10'h000, 8'h93, 1'b0);
    load_byte(10'h001, 8'h00, 1'b0);
    load_byte(10'h002, 8'h50, 1'b0);
    load_byte(10'h003, 8'h00, 1'b0);
    load_byte(10'h010, 8'hEF, 1'b0);
    load_byte(10'h011, 8'hBE, 1'b0);
    load_byte(10'h012, 8'hAD, 1'b0);
    load_byte(10'h013, 8'hDE, 1'b0);

    // Basic fetch
    resp_ready = 1'b1;
    fetch(32'h0);
    wait_idle(1'b0);
    chk("t1_word", {32'b0, last_data}, 64'h00500093);

    // Misaligned, then a normal fetch
    fetch(32'h6);
    wait_idle(1'b0);
    chk("t2_misaligned_err", {63'b0, last_err}, 64'd1);
    fetch(32'h4);
    wait_idle(1'b0);

    // Range edges
    fetch(32'h3FC);          wait_idle(1'b0);
    chk("t3_last_word_err", {63'b0, last_err}, 64'd0);
    fetch(32'h400);          wait_idle(1'b0);
    chk("t3_past_end_err", {63'b0, last_err}, 64'd1);
    fetch(32'h8000_0000);    wait_idle(1'b0);
    fetch(32'h3FD);          wait_idle(1'b0);
    fetch(32'hFFFF_FFFC);    wait_idle(1'b0);

    // Back-pressure in RESP
    resp_ready = 1'b0;
    fetch(32'h8);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    chk("t4_resp_seen", {63'b0, seen}, 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_ready_in_resp", {63'b0, req_ready}, 64'd0);
      chk("t4_valid_held", {63'b0, resp_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_ready_after", {63'b0, req_ready}, 64'd1);
    chk("t4_busy_after", {63'b0, busy}, 64'd0);

    // Load during WAIT does not alter the in-flight word
    fetch(32'h10);
    drive_load(10'h010, 8'h00);
    wait_idle(1'b0);
    chk("t5_inflight_word", {32'b0, last_data}, 64'hDEADBEEF);
    load_byte(10'h020, 8'h5A, 1'b1);
    fetch(32'h10);
    wait_idle(1'b0);
    chk("t5_updated_word", {32'b0, last_data}, 64'hDEADBE00);

    // Asynchronous reset mid-WAIT
    fetch(32'h0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("t6_resp_data", {32'b0, resp_data}, 64'd0);
    chk("t6_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    fetch(32'h0);
    wait_idle(1'b0);
    chk("t6_mem_kept", {32'b0, last_data}, 64'h00500093);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        load_byte(LAW'($urandom_range(0, DEPTH - 1)), 8'($urandom), 1'b0);
      end else begin
        case ($urandom_range(0, 4))
          0, 1, 2: a = {20'b0, 10'($urandom_range(0, 255)), 2'b00};
          3:       a = 32'($urandom_range(0, DEPTH - 1));
          default: a = $urandom;
        endcase
        fetch(a);
        wait_idle(1'b1);
      end
    end

    resp_ready = 1'b1;
    tick();
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
